// File: rtl/morse_pkg.sv
// Shared definitions for the Morse pipeline: sequence width, buffer FSM states
// and the all-zero "no sequence" code.
package morse_pkg;

  localparam int SEQ_W_DEFAULT = 10;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [SEQ_W_DEFAULT-1:0] BLANK_SEQ = {SEQ_W_DEFAULT{1'b0}};

endpackage

// File: rtl/morse_seq_buffer.sv
// Compacting sequence store: collects one or two sequences per cycle in
// FILL, then drains the committed sentence oldest-first over valid/ready.
module morse_seq_buffer
  import morse_pkg::*;
#(
  parameter  int SEQ_W = SEQ_W_DEFAULT,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Clear,
  input  logic                   WrEn,
  input  logic                   WrDual,
  input  logic [SEQ_W-1:0]       FirstSeq,
  input  logic [SEQ_W-1:0]       SecSeq,
  input  logic                   Enter,
  input  logic                   RdReady,
  output logic                   RdValid,
  output logic [SEQ_W-1:0]       RdSeq,
  output logic                   RdLast,
  output logic [CNT_W-1:0]       Count,
  output logic                   Full,
  output logic                   Overflow,
  output logic [DEPTH*SEQ_W-1:0] StoreFlat
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M2 = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C = CNT_W'(2);

  logic [SEQ_W-1:0] slots_q [DEPTH];
  logic [SEQ_W-1:0] slots_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;

  logic wr_first, wr_sec, pop;

  always_comb begin
    slots_d  = slots_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    wr_first = (state_q == ST_FILL) && WrEn && (count_q != DEPTH_C);
    wr_sec   = wr_first && WrDual && (count_q <= DEPTH_M2);
    pop      = (state_q == ST_DRAIN) && RdReady;

    // Any part of a write request that could not be stored is a drop.
    if (WrEn && ((state_q == ST_DRAIN) || !wr_first || (WrDual && !wr_sec)))
      ovf_d = 1'b1;

    if (state_q == ST_FILL) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_first && i == int'(count_q))
          slots_d[i] = FirstSeq;
        if (wr_sec && i == int'(count_q) + 1)
          slots_d[i] = SecSeq;
      end
      if (wr_sec)
        count_d = count_q + TWO_C;
      else if (wr_first)
        count_d = count_q + ONE_C;
      // Writes in the Enter cycle belong to the committed sentence.
      if (Enter && count_d != '0)
        state_d = ST_DRAIN;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        slots_d[i] = slots_q[i+1];
      slots_d[DEPTH-1] = SEQ_W'(BLANK_SEQ);
      count_d = count_q - ONE_C;
      if (count_q == ONE_C)
        state_d = ST_FILL;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      slots_q <= '{default: '0};
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= ST_FILL;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign RdValid  = (state_q == ST_DRAIN);
  assign RdSeq    = slots_q[0];
  assign RdLast   = RdValid && (count_q == ONE_C);
  assign Count    = count_q;
  assign Full     = (count_q == DEPTH_C);
  assign Overflow = ovf_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign StoreFlat[gi*SEQ_W +: SEQ_W] = slots_q[gi];
  end

endmodule

// File: tb/tb_morse_seq_buffer.sv
// Directed bench for morse_seq_buffer: a 16-deep and a 4-deep instance share
// stimulus; read data is checked against a queue of expected entries.
module tb_morse_seq_buffer;

  logic        clk = 1'b0;
  logic        reset, clear, wr_en, wr_dual, enter, rd_ready;
  logic [9:0]  first_seq, sec_seq;

  logic        rd_valid, rd_last, full, overflow;
  logic [9:0]  rd_seq;
  logic [4:0]  count;
  logic [159:0] store_flat;

  logic        c4_rd_valid, c4_rd_last, c4_full, c4_overflow;
  logic [9:0]  c4_rd_seq;
  logic [2:0]  c4_count;
  logic [39:0] c4_store_flat;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  morse_seq_buffer #(.SEQ_W(10), .DEPTH(16)) dut16 (
    .Clk(clk), .Reset(reset), .Clear(clear), .WrEn(wr_en), .WrDual(wr_dual),
    .FirstSeq(first_seq), .SecSeq(sec_seq), .Enter(enter), .RdReady(rd_ready),
    .RdValid(rd_valid), .RdSeq(rd_seq), .RdLast(rd_last), .Count(count),
    .Full(full), .Overflow(overflow), .StoreFlat(store_flat)
  );

  morse_seq_buffer #(.SEQ_W(10), .DEPTH(4)) dut4 (
    .Clk(clk), .Reset(reset), .Clear(clear), .WrEn(wr_en), .WrDual(wr_dual),
    .FirstSeq(first_seq), .SecSeq(sec_seq), .Enter(enter), .RdReady(rd_ready),
    .RdValid(c4_rd_valid), .RdSeq(c4_rd_seq), .RdLast(c4_rd_last), .Count(c4_count),
    .Full(c4_full), .Overflow(c4_overflow), .StoreFlat(c4_store_flat)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; wr_dual = 0; enter = 0; clear = 0; reset = 0;
  endtask

  task automatic wr1(input logic [9:0] a, input bit track);
    wr_en = 1; wr_dual = 0; first_seq = a;
    if (track) exp_q.push_back(a);
    tick();
    idle();
  endtask

  task automatic wr2(input logic [9:0] a, input logic [9:0] b, input bit with_enter);
    wr_en = 1; wr_dual = 1; first_seq = a; sec_seq = b; enter = with_enter;
    exp_q.push_back(a);
    exp_q.push_back(b);
    tick();
    idle();
  endtask

  task automatic read_step(input bit rdy);
    rd_ready = rdy;
    chk("rd_valid", rd_valid, 1'b1);
    chk("rd_seq", rd_seq, (exp_q.size() > 0) ? exp_q[0] : 10'h3ff);
    chk("rd_last", rd_last, exp_q.size() == 1);
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    while (exp_q.size() > 0 && n < 64) begin
      read_step(toggle ? (n % 2 == 0) : 1'b1);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    rd_ready = 0;
    chk("post_drain_valid", rd_valid, 1'b0);
    chk("post_drain_count", count, 0);
  endtask

  initial begin
    reset = 1; clear = 0; wr_en = 0; wr_dual = 0; enter = 0; rd_ready = 0;
    first_seq = '0; sec_seq = '0;
    tick();
    idle();
    $display("reset: count=%0d rd_valid=%0b", count, rd_valid);
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_flat", store_flat, 0);

    // Three single writes, then commit and drain them.
    wr1(10'h006, 1); wr1(10'h095, 1); wr1(10'h099, 1);
    $display("write x3: count=%0d flat=%0h", count, store_flat[29:0]);
    chk("s1_count", count, 3);
    chk("s1_flat", store_flat[29:0], {10'h099, 10'h095, 10'h006});
    chk("s1_full", full, 0);
    chk("s1_ovf", overflow, 0);
    enter = 1; tick(); idle();
    drain(0);

    // Dual write together with Enter.
    wr2(10'h006, 10'h095, 1);
    $display("dual+enter: rd_valid=%0b rd_seq=%0h", rd_valid, rd_seq);
    drain(0);

    // Fill the 16-deep buffer; the dual write at 15 keeps only FirstSeq.
    for (int i = 1; i <= 15; i++) wr1(10'(i), 0);
    wr_en = 1; wr_dual = 1; first_seq = 10'h3aa; sec_seq = 10'h155;
    tick(); idle();
    $display("fill16: count=%0d full=%0b ovf=%0b", count, full, overflow);
    chk("s3_count", count, 16);
    chk("s3_full", full, 1);
    chk("s3_ovf", overflow, 1);
    chk("s3_slot15", store_flat[159:150], 10'h3aa);
    chk("s3_slot14", store_flat[149:140], 10'h00f);
    wr1(10'h111, 0);
    chk("s3_count_held", count, 16);

    // Clear, then a 4-entry commit drained with RdReady toggling.
    clear = 1; tick(); idle();
    chk("s4_clr_ovf", overflow, 0);
    chk("s4_clr_count", count, 0);
    wr1(10'h0a1, 1); wr1(10'h0b2, 1); wr1(10'h0c3, 1); wr1(10'h0d4, 1);
    enter = 1; tick(); idle();
    $display("toggle drain start: count=%0d", count);
    drain(1);

    // Clear in the middle of a drain, with Enter in the same cycle.
    wr2(10'h011, 10'h022, 0);
    wr2(10'h033, 10'h044, 0);
    wr1(10'h055, 1);
    enter = 1; tick(); idle();
    wr_en = 1; first_seq = 10'h3ff;
    read_step(1);
    idle();
    read_step(1);
    chk("s5_ovf_set", overflow, 1);
    chk("s5_count_mid", count, 3);
    clear = 1; enter = 1; rd_ready = 1;
    tick(); idle(); rd_ready = 0;
    exp_q.delete();
    $display("clear mid-drain: count=%0d rd_valid=%0b ovf=%0b", count, rd_valid, overflow);
    chk("s5_count", count, 0);
    chk("s5_valid", rd_valid, 0);
    chk("s5_ovf", overflow, 0);
    chk("s5_flat", store_flat, 0);
    tick();
    chk("s5_fill_state", rd_valid, 0);

    // Enter on an empty buffer is ignored.
    enter = 1; tick(); idle();
    chk("s6_empty_enter", rd_valid, 0);
    tick();
    chk("s6_empty_enter2", rd_valid, 0);

    // A write while draining is dropped.
    wr1(10'h1c1, 1);
    wr1(10'h1c2, 1);
    enter = 1; tick(); idle();
    rd_ready = 0;
    wr_en = 1; first_seq = 10'h2ee; tick(); idle();
    $display("write in drain: count=%0d ovf=%0b", count, overflow);
    chk("s6_drain_count", count, 2);
    chk("s6_drain_ovf", overflow, 1);
    chk("s6_drain_valid", rd_valid, 1);
    drain(0);

    // 4-deep instance: full after four entries, dual at 3 drops SecSeq.
    clear = 1; tick(); idle();
    wr1(10'h041, 0); wr1(10'h042, 0); wr1(10'h043, 0);
    chk("d4_count3", c4_count, 3);
    chk("d4_full3", c4_full, 0);
    wr_en = 1; wr_dual = 1; first_seq = 10'h044; sec_seq = 10'h045;
    tick(); idle();
    $display("fill4: count=%0d full=%0b ovf=%0b", c4_count, c4_full, c4_overflow);
    chk("d4_count", c4_count, 4);
    chk("d4_full", c4_full, 1);
    chk("d4_ovf", c4_overflow, 1);
    chk("d4_slot3", c4_store_flat[39:30], 10'h044);
    wr1(10'h046, 0);
    chk("d4_count_held", c4_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
